// File: rtl/arcade_input.sv
// Player-input front end: merges PS/2 keys and joysticks, SOCD-cleans directions,
// stretches coin presses. `define ARCADE_INPUT_AUTOFIRE_EN adds autofire on fire0.
module arcade_input #(
    parameter int unsigned PLAYERS      = 2,
    parameter int unsigned BUTTONS      = 2,
    parameter logic [15:0] COIN_PULSE   = 16'd9600,
    parameter logic [19:0] AUTOFIRE_DIV = 20'd800000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [10:0]                  ps2_key,
    input  logic [16*PLAYERS-1:0]        joy,
    input  logic                         shared,
    input  logic [PLAYERS-1:0]           autofire,
    output logic [4*PLAYERS-1:0]         dir,
    output logic [BUTTONS*PLAYERS-1:0]   fire,
    output logic [PLAYERS-1:0]           start,
    output logic [PLAYERS-1:0]           coin
);
    localparam int unsigned NB         = BUTTONS + 6;
    localparam int unsigned START_BIT  = BUTTONS + 4;
    localparam int unsigned COIN_BIT   = BUTTONS + 5;
    localparam int unsigned KB_PLAYERS = (PLAYERS < 2) ? PLAYERS : 2;
    localparam int unsigned KB_FIRE    = (BUTTONS < 4) ? BUTTONS : 4;

    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_HOLD} coin_state_t;

    // Key bits per P1/P2: 0 right, 1 left, 2 down, 3 up, 4..7 fire0..3, 8 start, 9 coin
    logic             toggle_q;
    logic [1:0][9:0]  kb;
    logic             key_valid;
    logic             key_player;
    logic [3:0]       key_bit;

    always_comb begin
        key_valid  = 1'b1;
        key_player = 1'b0;
        key_bit    = '0;
        case (ps2_key[7:0])
            8'h75: key_bit = 4'd3;
            8'h72: key_bit = 4'd2;
            8'h6B: key_bit = 4'd1;
            8'h74: key_bit = 4'd0;
            8'h14: key_bit = 4'd4;
            8'h11: key_bit = 4'd5;
            8'h29: key_bit = 4'd6;
            8'h12: key_bit = 4'd7;
            8'h16: key_bit = 4'd8;
            8'h2E: key_bit = 4'd9;
            8'h2D: begin key_player = 1'b1; key_bit = 4'd3; end
            8'h2B: begin key_player = 1'b1; key_bit = 4'd2; end
            8'h23: begin key_player = 1'b1; key_bit = 4'd1; end
            8'h34: begin key_player = 1'b1; key_bit = 4'd0; end
            8'h1C: begin key_player = 1'b1; key_bit = 4'd4; end
            8'h1B: begin key_player = 1'b1; key_bit = 4'd5; end
            8'h15: begin key_player = 1'b1; key_bit = 4'd6; end
            8'h1D: begin key_player = 1'b1; key_bit = 4'd7; end
            8'h1E: begin key_player = 1'b1; key_bit = 4'd8; end
            8'h36: begin key_player = 1'b1; key_bit = 4'd9; end
            default: key_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            toggle_q <= 1'b0;
            kb       <= '0;
        end else begin
            toggle_q <= ps2_key[10];
            if ((ps2_key[10] != toggle_q) && key_valid)
                kb[key_player][key_bit] <= ps2_key[9];
        end
    end

    logic [PLAYERS-1:0][NB-1:0] joy_q, own, src;
    logic [NB-1:0]              any_src;
    logic [PLAYERS-1:0]         coin_src, coin_prev;

    // Raw joystick samples and coin history are left unreset so a coin held through reset is not a new press
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < PLAYERS; p++)
            joy_q[p] <= joy[16*p +: NB];
        coin_prev <= coin_src;
    end

    always_comb begin
        own     = joy_q;
        any_src = '0;
        for (int unsigned p = 0; p < KB_PLAYERS; p++) begin
            own[p][3:0] = joy_q[p][3:0] | kb[p[0]][3:0];
            for (int unsigned b = 0; b < KB_FIRE; b++)
                own[p][4+b] = joy_q[p][4+b] | kb[p[0]][4+b];
            own[p][START_BIT] = joy_q[p][START_BIT] | kb[p[0]][8];
            own[p][COIN_BIT]  = joy_q[p][COIN_BIT]  | kb[p[0]][9];
        end
        for (int unsigned p = 0; p < PLAYERS; p++)
            any_src = any_src | own[p];
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            src[p]      = shared ? any_src : own[p];
            coin_src[p] = src[p][COIN_BIT];
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic [19:0] af_cnt;
    logic        af_phase;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            af_cnt   <= '0;
            af_phase <= 1'b0;
        end else if (af_cnt == AUTOFIRE_DIV - 20'd1) begin
            af_cnt   <= '0;
            af_phase <= ~af_phase;
        end else begin
            af_cnt <= af_cnt + 20'd1;
        end
    end
`endif

    logic [4*PLAYERS-1:0]       dir_d;
    logic [BUTTONS*PLAYERS-1:0] fire_d;
    logic [PLAYERS-1:0]         start_d;

    always_comb begin
        dir_d   = '0;
        fire_d  = '0;
        start_d = '0;
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            dir_d[4*p+0] = src[p][0] & ~src[p][1];
            dir_d[4*p+1] = src[p][1] & ~src[p][0];
            dir_d[4*p+2] = src[p][2] & ~src[p][3];
            dir_d[4*p+3] = src[p][3] & ~src[p][2];
            fire_d[BUTTONS*p +: BUTTONS] = src[p][4 +: BUTTONS];
`ifdef ARCADE_INPUT_AUTOFIRE_EN
            fire_d[BUTTONS*p] = src[p][4] & (~autofire[p] | af_phase);
`endif
            start_d[p] = src[p][START_BIT];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dir   <= '0;
            fire  <= '0;
            start <= '0;
        end else begin
            dir   <= dir_d;
            fire  <= fire_d;
            start <= start_d;
        end
    end

    coin_state_t cst  [PLAYERS];
    logic [15:0] ccnt [PLAYERS];

    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            if (!reset_n) begin
                cst[p]  <= ST_IDLE;
                ccnt[p] <= '0;
                coin[p] <= 1'b0;
            end else begin
                case (cst[p])
                    ST_IDLE: if (coin_src[p] && !coin_prev[p]) begin
                        cst[p]  <= ST_PULSE;
                        ccnt[p] <= COIN_PULSE - 16'd1;
                        coin[p] <= 1'b1;
                    end
                    ST_PULSE: if (ccnt[p] == '0) begin
                        cst[p]  <= ST_HOLD;
                        coin[p] <= 1'b0;
                    end else begin
                        ccnt[p] <= ccnt[p] - 16'd1;
                    end
                    ST_HOLD: if (!coin_src[p]) cst[p] <= ST_IDLE;
                    default: cst[p] <= ST_IDLE;
                endcase
            end
        end
    end

    logic unused_bits;
    always_comb begin
        unused_bits = ps2_key[8] ^ (^kb);
        for (int unsigned p = 0; p < PLAYERS; p++)
            for (int unsigned i = NB; i < 16; i++)
                unused_bits = unused_bits ^ joy[16*p+i];
`ifndef ARCADE_INPUT_AUTOFIRE_EN
        unused_bits = unused_bits ^ (^autofire) ^ (^AUTOFIRE_DIV);
`endif
    end

endmodule
